// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
// Holds the FSM state encoding and a width helper.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAULT
    } pll_sup_state_t;

    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int DEF_STABLE_CYC       = 1024;
    localparam int DEF_MAX_RETRIES      = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, async active-low reset to 0.
// Used to bring the PLL lock flag into the refclk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor FSM with bounded lock retries.
// Define PLL_SUP_LOSS_CNT_EN to add the saturating loss_cnt output.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int STABLE_CYC       = DEF_STABLE_CYC,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic                             refclk,
    input  logic                             rst_n,
    input  logic                             locked,
    input  logic                             req_relock,
    output logic                             pll_rst,
    output logic                             sys_rst_n,
    output logic                             ready,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    output logic [7:0]                       loss_cnt
`endif
);

    localparam int RW    = $clog2(MAX_RETRIES + 1);
    localparam int CNT_W =
        $clog2(max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC) + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [RW-1:0]    RETRY_LIM = RW'(MAX_RETRIES);

    logic           locked_s;
    pll_sup_state_t state;
    pll_sup_state_t state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [RW-1:0]    retry_nxt;
    logic [RW-1:0]    retry_inc;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk  (refclk),
        .rst_n(rst_n),
        .d    (locked),
        .q    (locked_s)
    );

    assign retry_inc = retry_cnt + RW'(1);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            cnt       <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Lock seen on the timeout cycle wins over the retry path.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        unique case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABILIZE;
                end else if (cnt == TO_LAST) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_LIM) ? FAULT : RESET_PLL;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STB_LAST) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end
            end
            RUN: begin
                if (!locked_s || req_relock) state_nxt = RESET_PLL;
            end
            FAULT: begin
                if (req_relock) begin
                    state_nxt = RESET_PLL;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = RESET_PLL;
        endcase
    end

    always_comb begin
        pll_rst   = 1'b1;
        sys_rst_n = 1'b0;
        ready     = 1'b0;
        fault     = 1'b0;
        unique case (state)
            RESET_PLL: pll_rst = 1'b1;
            WAIT_LOCK: pll_rst = 1'b0;
            STABILIZE: pll_rst = 1'b0;
            RUN: begin
                pll_rst   = 1'b0;
                sys_rst_n = 1'b1;
                ready     = 1'b1;
            end
            FAULT: fault = 1'b1;
            default: pll_rst = 1'b1;
        endcase
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    // Only lock loss counts; relock requests leave it untouched.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if (state == RUN && !locked_s && loss_cnt != 8'hFF) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
// Define PLL_SUP_LOSS_CNT_EN to also check loss_cnt.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst_n;
    logic       locked;
    logic       req_relock;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
`ifdef PLL_SUP_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYC   (4),
        .LOCK_TIMEOUT_CYC(20),
        .STABLE_CYC      (8),
        .MAX_RETRIES     (2)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .locked    (locked),
        .req_relock(req_relock),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt)
`ifdef PLL_SUP_LOSS_CNT_EN
        ,
        .loss_cnt  (loss_cnt)
`endif
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        string      nm;
        logic       rst_n;
        logic       locked;
        logic       relock;
        int         n;
        logic       pll;
        logic       sys;
        logic       rdy;
        logic       flt;
        logic [1:0] retry;
        logic [7:0] loss;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic r,
                                input logic l, input logic q, input int n,
                                input logic p, input logic s, input logic y,
                                input logic f, input logic [1:0] rc,
                                input logic [7:0] lc);
        vec_t v;
        v.nm = nm; v.rst_n = r; v.locked = l; v.relock = q; v.n = n;
        v.pll = p; v.sys = s; v.rdy = y; v.flt = f;
        v.retry = rc; v.loss = lc;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic p, input logic s,
                           input logic y, input logic f,
                           input logic [1:0] rc);
        chk({nm, ".pll_rst"}, 32'(pll_rst), 32'(p));
        chk({nm, ".sys_rst_n"}, 32'(sys_rst_n), 32'(s));
        chk({nm, ".ready"}, 32'(ready), 32'(y));
        chk({nm, ".fault"}, 32'(fault), 32'(f));
        chk({nm, ".retry_cnt"}, 32'(retry_cnt), 32'(rc));
    endtask

    initial begin
        rst_n = 1'b0;
        locked = 1'b0;
        req_relock = 1'b0;

        //                 name       rst lk rq  n  pll sys rdy flt rc loss
        tbl.push_back(mk("reset",     0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("pulse_hi",  1, 0, 0,  3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("pulse_end", 1, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("wait5",     1, 0, 0,  4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("stab",      1, 1, 0, 10, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("run",       1, 1, 0,  1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk("relock",    1, 1, 1,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rl_pulse",  1, 1, 0,  3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rl_wait",   1, 1, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rl_stab",   1, 1, 0,  8, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rl_run",    1, 1, 0,  1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk("reset2",    0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("to_pulse",  1, 0, 0,  3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("to_wait0",  1, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("to_win1",   1, 0, 0, 19, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("timeout1",  1, 0, 0,  1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("retry_pls", 1, 0, 0,  3, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("to_wait1",  1, 0, 0,  1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("to_win2",   1, 0, 0, 19, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("fault",     1, 0, 0,  1, 1, 0, 0, 1, 2, 0));
        tbl.push_back(mk("flt_hold",  1, 0, 0,  5, 1, 0, 0, 1, 2, 0));
        tbl.push_back(mk("flt_clr",   1, 0, 1,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("clr_pulse", 1, 0, 0,  3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("clr_wait",  1, 0, 0,  1, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            rst_n      = tbl[i].rst_n;
            locked     = tbl[i].locked;
            req_relock = tbl[i].relock;
            step(tbl[i].n);
            chk_all(tbl[i].nm, tbl[i].pll, tbl[i].sys, tbl[i].rdy,
                    tbl[i].flt, tbl[i].retry);
`ifdef PLL_SUP_LOSS_CNT_EN
            chk({tbl[i].nm, ".loss_cnt"}, 32'(loss_cnt), 32'(tbl[i].loss));
`endif
        end

        // Reach RUN from WAIT_LOCK.
        req_relock = 1'b0;
        locked = 1'b1;
        step(10);
        chk("t3_pre_stab.ready", 32'(ready), 32'd0);
        step(1);
        chk("t3_pre_run.ready", 32'(ready), 32'd1);

        // One-cycle lock drop in RUN.
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        chk("t3_drop1.sys_rst_n", 32'(sys_rst_n), 32'd1);
        step(1);
        chk("t3_drop2.sys_rst_n", 32'(sys_rst_n), 32'd1);
        step(1);
        chk_all("t3_loss", 1, 0, 0, 0, 0);
`ifdef PLL_SUP_LOSS_CNT_EN
        chk("t3_loss.loss_cnt", 32'(loss_cnt), 32'd1);
`endif

        // Lock drop at the 5th STABILIZE cycle.
        step(5);
        chk("t4_stab.pll_rst", 32'(pll_rst), 32'd0);
        step(4);
        locked = 1'b0;
        step(3);
        chk("t4_back.ready", 32'(ready), 32'd0);
        locked = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("t4_restab.ready", 32'(ready), 32'd0);
        end
        step(1);
        chk_all("t4_run", 0, 1, 1, 0, 0);

        // Async reset in the middle of STABILIZE.
        req_relock = 1'b1;
        step(1);
        req_relock = 1'b0;
        chk("t5_rl.pll_rst", 32'(pll_rst), 32'd1);
`ifdef PLL_SUP_LOSS_CNT_EN
        chk("t6_rl.loss_cnt", 32'(loss_cnt), 32'd1);
`endif
        step(4);
        chk("t5_wait.pll_rst", 32'(pll_rst), 32'd0);
        step(4);
        chk("t5_stab.ready", 32'(ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t5_async", 1, 0, 0, 0, 0);
`ifdef PLL_SUP_LOSS_CNT_EN
        chk("t5_async.loss_cnt", 32'(loss_cnt), 32'd0);
`endif
        step(1);
        rst_n = 1'b1;
        locked = 1'b0;

        // Lock arriving exactly on the timeout cycle.
        step(3);
        chk("p_pulse.pll_rst", 32'(pll_rst), 32'd1);
        step(1);
        chk("p_wait.pll_rst", 32'(pll_rst), 32'd0);
        step(17);
        locked = 1'b1;
        step(2);
        chk_all("p_pre", 0, 0, 0, 0, 0);
        step(1);
        chk_all("p_tie", 0, 0, 0, 0, 0);
        step(7);
        chk("p_stab.ready", 32'(ready), 32'd0);
        step(1);
        chk_all("p_run", 0, 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
